// File: rtl/grayscale_pipe.sv
// grayscale_pipe: 3-stage valid/ready RGB-to-grayscale converter with frame tags, pixel index and sticky frame error.
// Optional build macro GRAY_ROUND_EN: round half up before the final shift (default build truncates).
module grayscale_pipe #(
  parameter int CW               = 8,
  parameter int FRAC             = 0,
  parameter int WR               = 77,
  parameter int WG               = 150,
  parameter int WB               = 29,
  parameter int PIXELS_PER_FRAME = 307200,
  parameter int IW               = $clog2(PIXELS_PER_FRAME)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_data_valid,
  output logic                 ou_data_ready,
  input  logic [3*CW+7:0]      in_rgb_pixel,
  output logic                 ou_result_valid,
  input  logic                 in_result_ready,
  output logic [CW+FRAC-1:0]   ou_grayscale_pixel,
  output logic                 ou_first_frame,
  output logic                 ou_pre_last,
  output logic                 ou_last_frame,
  output logic [IW-1:0]        ou_pixel_index,
  output logic                 ou_frame_error
);

  localparam int SW    = CW + 10;
  localparam int PW    = CW + 8;
  localparam int OW    = CW + FRAC;
  localparam int SHIFT = 8 - FRAC;
  localparam logic [IW-1:0] LAST_IDX = IW'(PIXELS_PER_FRAME - 1);

`ifdef GRAY_ROUND_EN
  localparam int RND = (FRAC < 8) ? (1 << ((FRAC < 8) ? (7 - FRAC) : 0)) : 0;
`else
  localparam int RND = 0;
`endif

  // Stage valids and load enables
  logic v1_reg, v2_reg, v3_reg;
  logic ld1, ld2, ld3;
  logic out_hs, in_hs;

  // Output valid is masked during rst so no handshake can complete while resetting.
  assign ou_result_valid = v3_reg & ~rst;
  assign out_hs          = ou_result_valid & in_result_ready;
  assign ld3             = ~v3_reg | out_hs;
  assign ld2             = ~v2_reg | ld3;
  assign ld1             = ~v1_reg | ld2;
  assign ou_data_ready   = ld1 & ~rst;
  assign in_hs           = in_data_valid & ou_data_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
    end else begin
      if (ld1) v1_reg <= in_data_valid;
      if (ld2) v2_reg <= v1_reg;
      if (ld3) v3_reg <= v2_reg;
    end
  end

  // Footer decode
  logic [7:0] footer;
  logic [2:0] tag_in;
  always_comb begin
    footer = in_rgb_pixel[3*CW +: 8];
    tag_in = {footer == 8'd3, footer == 8'd2, footer == 8'd1};
  end

  // Index tracker and framing checks, evaluated on the incoming word
  logic [IW-1:0] idx_reg, idx_next, pix_idx;
  logic          err_hit;
  always_comb begin
    idx_next = idx_reg;
    pix_idx  = idx_reg;
    err_hit  = 1'b0;
    if (tag_in[0]) begin
      pix_idx  = '0;
      err_hit  = (idx_reg != '0);
      idx_next = IW'(1);
    end else if (tag_in[2]) begin
      err_hit  = (idx_reg != LAST_IDX);
      idx_next = '0;
    end else if (idx_reg == LAST_IDX) begin
      err_hit  = 1'b1;
      idx_next = '0;
    end else begin
      idx_next = idx_reg + IW'(1);
    end
  end

  logic frame_error_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg         <= '0;
      frame_error_reg <= 1'b0;
    end else if (in_hs) begin
      idx_reg <= idx_next;
      if (err_hit) frame_error_reg <= 1'b1;
    end
  end
  assign ou_frame_error = frame_error_reg;

  // Per-channel S1 capture and S2 weighting; channel 0 is blue (LSBs), 2 is red.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      localparam logic [7:0] W = (gi == 0) ? 8'(WB) : (gi == 1) ? 8'(WG) : 8'(WR);
      logic [CW-1:0] ch1_reg;
      logic [PW-1:0] prod2_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          ch1_reg   <= '0;
          prod2_reg <= '0;
        end else begin
          if (in_hs)           ch1_reg   <= in_rgb_pixel[gi*CW +: CW];
          if (ld2 && v1_reg)   prod2_reg <= PW'(ch1_reg) * PW'(W);
        end
      end
    end
  endgenerate

  // Side-band (tags, index) follows the pixel through S1 and S2
  logic [2:0]    tag1_reg, tag2_reg;
  logic [IW-1:0] idx1_reg, idx2_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_reg <= '0;
      idx1_reg <= '0;
      tag2_reg <= '0;
      idx2_reg <= '0;
    end else begin
      if (in_hs) begin
        tag1_reg <= tag_in;
        idx1_reg <= pix_idx;
      end
      if (ld2 && v1_reg) begin
        tag2_reg <= tag1_reg;
        idx2_reg <= idx1_reg;
      end
    end
  end

  // S3: sum, optional rounding, shift and saturate
  logic [SW-1:0] sum_next, shifted;
  logic [OW-1:0] gray_next;
  always_comb begin
    sum_next  = SW'(g_ch[0].prod2_reg) + SW'(g_ch[1].prod2_reg)
              + SW'(g_ch[2].prod2_reg) + SW'(RND);
    shifted   = sum_next >> SHIFT;
    gray_next = (|shifted[SW-1:OW]) ? '1 : shifted[OW-1:0];
  end

  logic [OW-1:0] gray_reg;
  logic [2:0]    tag3_reg;
  logic [IW-1:0] idx3_reg;
  // S3 only reloads when empty or draining, so outputs hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      gray_reg <= '0;
      tag3_reg <= '0;
      idx3_reg <= '0;
    end else if (ld3 && v2_reg) begin
      gray_reg <= gray_next;
      tag3_reg <= tag2_reg;
      idx3_reg <= idx2_reg;
    end
  end

  assign ou_grayscale_pixel = gray_reg;
  assign ou_first_frame     = tag3_reg[0];
  assign ou_pre_last        = tag3_reg[1];
  assign ou_last_frame      = tag3_reg[2];
  assign ou_pixel_index     = idx3_reg;

endmodule
